// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide: one result bit per clock.
// Results land in hi/lo; busy stalls the pipeline while iterating.
module muldiv_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 op_q;
  logic [WIDTH-1:0]     m_q;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       rem;
  logic [WIDTH-1:0]     diff;
  logic                 lt;

  // m_q is the multiplicand for multiply and the divisor for divide
  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
    rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    lt   = rem < {1'b0, m_q};
    diff = rem[WIDTH-1:0] - m_q;
    acc_nxt = acc;
    if (op_q) begin
      if (lt)
        acc_nxt = {rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_nxt = {diff, acc[WIDTH-2:0], 1'b1};
    end else begin
      if (acc[0])
        acc_nxt = {sum, acc[WIDTH-1:1]};
      else
        acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= 1'b0;
      m_q         <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q        <= op;
            m_q         <= op ? b : a;
            div_by_zero <= 1'b0;
            if (op && b == '0) begin
              hi          <= a;
              lo          <= '1;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              acc   <= {{WIDTH{1'b0}}, op ? a : b};
              cnt   <= CW'(WIDTH);
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            hi    <= acc_nxt[2*WIDTH-1:WIDTH];
            lo    <= acc_nxt[WIDTH-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit.
// Expected results are queued at issue and popped on done.
module tb_muldiv_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] hi;
  logic [7:0] lo;
  logic       div_by_zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       dz;
    int         lat;
  } exp_t;

  exp_t sb[$];

  muldiv_unit #(.WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge (edge 0); start is sampled at edge 1.
  task automatic run_op(input logic o, input logic [7:0] x,
                        input logic [7:0] y, input bit noise);
    exp_t e;
    exp_t g;
    bit seen;
    logic [15:0] p;
    logic [7:0] ph;
    logic [7:0] pl;
    if (o && y == 8'd0) begin
      e.hi = x; e.lo = 8'hFF; e.dz = 1'b1; e.lat = 1;
    end else if (o) begin
      e.hi = x % y; e.lo = x / y; e.dz = 1'b0; e.lat = 9;
    end else begin
      p = 16'(x) * 16'(y);
      e.hi = p[15:8]; e.lo = p[7:0]; e.dz = 1'b0; e.lat = 9;
    end
    sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    seen = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        start = 1'b0;
        op = ~o;
        a = 8'($urandom);
        b = 8'($urandom);
      end
      if (noise && n == 4) begin
        start = 1'b1;
        op = 1'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
      end
      if (noise && n == 5) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        g = sb.pop_front();
        check("latency", n, g.lat);
        check("hi", hi, g.hi);
        check("lo", lo, g.lo);
        check("dbz", div_by_zero, g.dz);
        check("busy_done", busy, 0);
        if (noise) start = 1'b1;
      end else if (n < e.lat) begin
        check("busy_run", busy, 1);
      end
    end
    if (!seen) begin
      check("timeout", 0, 1);
      void'(sb.pop_front());
    end
    ph = hi;
    pl = lo;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse", done, 0);
    check("hi_hold", hi, ph);
    check("lo_hold", lo, pl);
    if (noise) begin
      seen = 1'b0;
      for (int n = 0; n < 12; n++) begin
        @(posedge clk); #1;
        if (done) seen = 1'b1;
      end
      check("no_extra_done", seen, 0);
      check("hi_final", hi, ph);
      check("lo_final", lo, pl);
    end
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    op = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_dbz", div_by_zero, 0);
    reset = 1'b0;

    run_op(1'b0, 8'd13, 8'd11, 1'b0);
    run_op(1'b0, 8'hFF, 8'hFF, 1'b0);
    run_op(1'b1, 8'd200, 8'd7, 1'b0);
    run_op(1'b1, 8'd5, 8'd9, 1'b0);
    run_op(1'b1, 8'h35, 8'd0, 1'b0);
    run_op(1'b0, 8'd2, 8'd3, 1'b0);
    run_op(1'b0, 8'h5A, 8'h3C, 1'b1);
    run_op(1'b1, 8'hE9, 8'h0D, 1'b1);

    // abort a multiply with reset sampled at edge 4
    start = 1'b1; op = 1'b0; a = 8'h77; b = 8'h33;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("abort_busy_pre", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("abort_quiet", seen, 0);

    run_op(1'b1, 8'd100, 8'd10, 1'b0);
    for (int i = 0; i < 6; i++)
      run_op(1'($urandom), 8'($urandom), 8'($urandom_range(0, 20)), 1'b0);

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
